// File: rtl/vscale_fwb_arbiter.sv
// Write-back controller for the 32-entry FP register file.
// Two requesters (LSU load returns, FPU results) share the file's single
// write port. A round-robin arbiter grants at most one transfer per cycle,
// and the winning write is registered onto rf_wen/rf_wa/rf_wd. A per-register
// busy scoreboard tracks writes still outstanding so that issue logic can
// stall on RAW/WAW hazards.
//
//   last_grant | meaning
//   -----------+----------------------------------------------------------
//   GRANT_LSU  | LSU won the most recent transfer; FPU wins the next tie
//   GRANT_FPU  | FPU won the most recent transfer; LSU wins the next tie
//
// Reset leaves last_grant at GRANT_FPU so that the LSU takes the first tie.
module vscale_fwb_arbiter #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,

  // Scoreboard set port from the issue stage
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       issue_rd,

  // Operands of the instruction sitting in decode
  input  logic [ADDR_W-1:0]       chk_rs1,
  input  logic [ADDR_W-1:0]       chk_rs2,
  input  logic [ADDR_W-1:0]       chk_rs3,
  input  logic [ADDR_W-1:0]       chk_rd,
  output logic                    hazard,

  // LSU write-back request
  input  logic                    lsu_wb_valid,
  input  logic [ADDR_W-1:0]       lsu_wb_addr,
  input  logic [XLEN-1:0]         lsu_wb_data,
  output logic                    lsu_wb_ready,

  // FPU write-back request
  input  logic                    fpu_wb_valid,
  input  logic [ADDR_W-1:0]       fpu_wb_addr,
  input  logic [XLEN-1:0]         fpu_wb_data,
  output logic                    fpu_wb_ready,

  // Register-file write port
  output logic                    rf_wen,
  output logic [ADDR_W-1:0]       rf_wa,
  output logic [XLEN-1:0]         rf_wd,

  output logic [(2**ADDR_W)-1:0]  busy_vec,
  output logic                    wb_err
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic {
    GRANT_LSU = 1'b0,
    GRANT_FPU = 1'b1
  } grant_e;

  grant_e              r_last_grant;
  logic                r_rf_wen;
  logic [ADDR_W-1:0]   r_rf_wa;
  logic [XLEN-1:0]     r_rf_wd;
  logic [NREG-1:0]     r_busy;
  logic                r_wb_err;

  logic                w_grant_lsu;
  logic                w_grant_fpu;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_wb_addr;
  logic [XLEN-1:0]     w_wb_data;
  logic                w_addr_busy;
  logic [NREG-1:0]     w_busy_nxt;

  // Round-robin grant: a lone requester always wins; on a tie the source
  // that did not win the previous transfer goes first. Depends only on the
  // valids and last_grant, never on addr/data, so ready carries no data path.
  always_comb begin
    w_grant_lsu = lsu_wb_valid & (~fpu_wb_valid | (r_last_grant == GRANT_FPU));
    w_grant_fpu = fpu_wb_valid & (~lsu_wb_valid | (r_last_grant == GRANT_LSU));
  end

  assign lsu_wb_ready = w_grant_lsu;
  assign fpu_wb_ready = w_grant_fpu;
  assign w_xfer       = w_grant_lsu | w_grant_fpu;

  // Select the winning request's address and data for the output stage.
  always_comb begin
    w_wb_addr = fpu_wb_addr;
    w_wb_data = fpu_wb_data;
    if (w_grant_lsu) begin
      w_wb_addr = lsu_wb_addr;
      w_wb_data = lsu_wb_data;
    end
  end

  assign w_addr_busy = r_busy[w_wb_addr];

  // Scoreboard next state: the file write clears its register, a new issue
  // sets its register, and the set is applied last so it wins a collision.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_wen) begin
      w_busy_nxt[r_rf_wa] = 1'b0;
    end
    if (issue_valid) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
  end

  // Arbiter history: only a real transfer moves the round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= GRANT_FPU;
    end else if (w_xfer) begin
      r_last_grant <= w_grant_lsu ? GRANT_LSU : GRANT_FPU;
    end
  end

  // Output stage: one registered write per transfer; address and data hold
  // their last values on idle cycles so the file port does not toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rf_wen <= 1'b0;
      r_rf_wa  <= '0;
      r_rf_wd  <= '0;
    end else begin
      r_rf_wen <= w_xfer;
      if (w_xfer) begin
        r_rf_wa <= w_wb_addr;
        r_rf_wd <= w_wb_data;
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Sticky error: a transfer landed on a register nobody was waiting for.
  // The write itself still goes through; this only flags the inconsistency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_err <= 1'b0;
    end else if (w_xfer && !w_addr_busy) begin
      r_wb_err <= 1'b1;
    end
  end

  assign hazard = r_busy[chk_rs1] | r_busy[chk_rs2] | r_busy[chk_rs3] | r_busy[chk_rd];

  assign rf_wen   = r_rf_wen;
  assign rf_wa    = r_rf_wa;
  assign rf_wd    = r_rf_wd;
  assign busy_vec = r_busy;
  assign wb_err   = r_wb_err;

endmodule

// File: tb/tb_vscale_fwb_arbiter.sv
// Directed bench for the FP write-back arbiter and busy scoreboard.
module tb_vscale_fwb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1, chk_rs2, chk_rs3, chk_rd;
  logic        hazard;
  logic        lsu_wb_valid;
  logic [4:0]  lsu_wb_addr;
  logic [31:0] lsu_wb_data;
  logic        lsu_wb_ready;
  logic        fpu_wb_valid;
  logic [4:0]  fpu_wb_addr;
  logic [31:0] fpu_wb_data;
  logic        fpu_wb_ready;
  logic        rf_wen;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy_vec;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  vscale_fwb_arbiter #(.XLEN(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .chk_rs1      (chk_rs1),
    .chk_rs2      (chk_rs2),
    .chk_rs3      (chk_rs3),
    .chk_rd       (chk_rd),
    .hazard       (hazard),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_addr  (lsu_wb_addr),
    .lsu_wb_data  (lsu_wb_data),
    .lsu_wb_ready (lsu_wb_ready),
    .fpu_wb_valid (fpu_wb_valid),
    .fpu_wb_addr  (fpu_wb_addr),
    .fpu_wb_data  (fpu_wb_data),
    .fpu_wb_ready (fpu_wb_ready),
    .rf_wen       (rf_wen),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .busy_vec     (busy_vec),
    .wb_err       (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    issue_valid  = 1'b0;
    issue_rd     = '0;
    chk_rs1      = '0;
    chk_rs2      = '0;
    chk_rs3      = '0;
    chk_rd       = '0;
    lsu_wb_valid = 1'b0;
    lsu_wb_addr  = '0;
    lsu_wb_data  = '0;
    fpu_wb_valid = 1'b0;
    fpu_wb_addr  = '0;
    fpu_wb_data  = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_wb_err", wb_err, 0);
    chk("rst_hazard", hazard, 0);

    // Single FPU write to register 5
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    tick();
    issue_valid = 1'b0;
    chk_rs1     = 5'd5;
    chk("single_busy_set", busy_vec, 32'h0000_0020);
    fpu_wb_valid = 1'b1;
    fpu_wb_addr  = 5'd5;
    fpu_wb_data  = 32'h3F80_0000;
    #1;
    chk("single_fpu_ready", fpu_wb_ready, 1);
    chk("single_lsu_ready", lsu_wb_ready, 0);
    chk("single_hazard_pre", hazard, 1);
    tick();
    fpu_wb_valid = 1'b0;
    chk("single_rf_wen", rf_wen, 1);
    chk("single_rf_wa", rf_wa, 5);
    chk("single_rf_wd", rf_wd, 32'h3F80_0000);
    chk("single_busy_hold", busy_vec, 32'h0000_0020);
    chk("single_hazard_hold", hazard, 1);
    tick();
    chk("single_rf_wen_idle", rf_wen, 0);
    chk("single_rf_wa_hold", rf_wa, 5);
    chk("single_rf_wd_hold", rf_wd, 32'h3F80_0000);
    chk("single_busy_clr", busy_vec, 0);
    chk("single_hazard_clr", hazard, 0);
    chk("single_wb_err", wb_err, 0);
    chk_rs1 = '0;

    // Contention: LSU -> r1, FPU -> r2; last winner was FPU so LSU goes first.
    // Re-issuing r1/r2 while their writes retire keeps both busy (set beats clear).
    issue_valid = 1'b1;
    issue_rd    = 5'd1;
    tick();
    issue_rd    = 5'd2;
    tick();
    issue_valid = 1'b0;
    chk("cont_busy_pre", busy_vec, 32'h0000_0006);
    lsu_wb_valid = 1'b1;
    lsu_wb_addr  = 5'd1;
    lsu_wb_data  = 32'hAAAA_0001;
    fpu_wb_valid = 1'b1;
    fpu_wb_addr  = 5'd2;
    fpu_wb_data  = 32'hBBBB_0002;
    for (int i = 0; i < 4; i++) begin
      issue_valid = (i == 1) || (i == 2);
      issue_rd    = (i == 1) ? 5'd1 : 5'd2;
      #1;
      chk($sformatf("cont_lsu_ready_%0d", i), lsu_wb_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("cont_fpu_ready_%0d", i), fpu_wb_ready, (i % 2 == 1) ? 1 : 0);
      if (i > 0) begin
        chk($sformatf("cont_rf_wen_%0d", i), rf_wen, 1);
        chk($sformatf("cont_rf_wa_%0d", i), rf_wa, (i % 2 == 1) ? 1 : 2);
        chk($sformatf("cont_rf_wd_%0d", i), rf_wd,
            (i % 2 == 1) ? 32'hAAAA_0001 : 32'hBBBB_0002);
      end
      tick();
    end
    issue_valid  = 1'b0;
    lsu_wb_valid = 1'b0;
    fpu_wb_valid = 1'b0;
    chk("cont_rf_wa_last", rf_wa, 2);
    chk("cont_rf_wd_last", rf_wd, 32'hBBBB_0002);
    chk("cont_busy_last", busy_vec, 32'h0000_0004);
    tick();
    chk("cont_busy_drained", busy_vec, 0);
    chk("cont_wb_err", wb_err, 0);

    // Set/clear collision on register 7
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    issue_valid  = 1'b0;
    lsu_wb_valid = 1'b1;
    lsu_wb_addr  = 5'd7;
    lsu_wb_data  = 32'h0000_0777;
    tick();
    lsu_wb_valid = 1'b0;
    chk("coll_rf_wen", rf_wen, 1);
    chk("coll_rf_wa", rf_wa, 7);
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    issue_valid = 1'b0;
    chk("coll_busy7", busy_vec, 32'h0000_0080);
    lsu_wb_valid = 1'b1;
    tick();
    lsu_wb_valid = 1'b0;
    tick();
    chk("coll_busy_drained", busy_vec, 0);
    chk("coll_wb_err", wb_err, 0);

    // Error: write to non-busy register 9
    lsu_wb_valid = 1'b1;
    lsu_wb_addr  = 5'd9;
    lsu_wb_data  = 32'h1234_5678;
    #1;
    chk("err_lsu_ready", lsu_wb_ready, 1);
    chk("err_wb_err_pre", wb_err, 0);
    tick();
    lsu_wb_valid = 1'b0;
    chk("err_rf_wen", rf_wen, 1);
    chk("err_rf_wa", rf_wa, 9);
    chk("err_rf_wd", rf_wd, 32'h1234_5678);
    chk("err_wb_err", wb_err, 1);
    tick();
    tick();
    chk("err_wb_err_sticky", wb_err, 1);
    chk("err_busy", busy_vec, 0);

    // Hazard operand ports, register 31 busy only
    issue_valid = 1'b1;
    issue_rd    = 5'd31;
    tick();
    issue_valid = 1'b0;
    chk("haz_busy31", busy_vec, 32'h8000_0000);
    chk("haz_none", hazard, 0);
    for (int k = 0; k < 4; k++) begin
      chk_rs1 = (k == 0) ? 5'd31 : 5'd0;
      chk_rs2 = (k == 1) ? 5'd31 : 5'd0;
      chk_rs3 = (k == 2) ? 5'd31 : 5'd0;
      chk_rd  = (k == 3) ? 5'd31 : 5'd0;
      #1;
      chk($sformatf("haz_port_%0d", k), hazard, 1);
    end
    chk_rd  = 5'd30;
    #1;
    chk("haz_r30", hazard, 0);
    chk_rd  = '0;

    // Tie history: last winner LSU, so FPU then LSU; last_grant ends at LSU
    lsu_wb_valid = 1'b1;
    lsu_wb_addr  = 5'd3;
    lsu_wb_data  = 32'h0000_0033;
    fpu_wb_valid = 1'b1;
    fpu_wb_addr  = 5'd4;
    fpu_wb_data  = 32'h0000_0044;
    #1;
    chk("tie1_fpu_ready", fpu_wb_ready, 1);
    chk("tie1_lsu_ready", lsu_wb_ready, 0);
    tick();
    chk("tie2_lsu_ready", lsu_wb_ready, 1);
    tick();
    chk("tie2_rf_wa", rf_wa, 3);
    chk("tie2_rf_wen", rf_wen, 1);

    // Asynchronous reset mid-cycle with both sources valid
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_rf_wen", rf_wen, 0);
    chk("arst_rf_wa", rf_wa, 0);
    chk("arst_rf_wd", rf_wd, 0);
    chk("arst_busy", busy_vec, 0);
    chk("arst_wb_err", wb_err, 0);
    #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_lsu_ready", lsu_wb_ready, 1);
    chk("post_rst_fpu_ready", fpu_wb_ready, 0);
    tick();
    lsu_wb_valid = 1'b0;
    fpu_wb_valid = 1'b0;
    chk("post_rst_rf_wa", rf_wa, 3);
    chk("post_rst_rf_wd", rf_wd, 32'h0000_0033);
    chk("post_rst_wb_err", wb_err, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
